spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front end (mode 0, MSB-first bits) from the ESP32 host link to the core register stage.
//  Oversamples SCLK/SSEL_n/MOSI in clk, frames each select window as <cmd byte><0..n data bytes>, and
//  presents spi_cmd/spi_rxdata with a one-cycle spi_msg_end at deselect. Returns spi_txdata on MISO.
//  Feeds the SPI command/register decoder directly.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer flops per async input (min 2); an edge-detect flop follows
// PORTS
//  clk               in   1   system clock; one clock, all logic on posedge
//  reset_n           in   1   reset is synchronous and active-low
//  spi_sclk          in   1   async SPI clock, idle low; freq <= clk/8
//  spi_ssel_n        in   1   async chip select, active low
//  spi_mosi          in   1   async host->core data
//  spi_miso          out  1   core->host data, registered
//  spi_cmd           out  8   first byte of current/last message
//  spi_rxdata        out  64  data bytes; byte i of an N-byte msg (N<=8) at [8*(8-N+i)+7 : 8*(8-N+i)]
//  spi_rxlen         out  4   complete data bytes received, saturates at 8
//  spi_msg_end       out  1   1-cycle pulse: message complete, outputs stable
//  spi_txdata        in   64  response; sampled once at cmd byte completion
//  spi_txdata_valid  in   1   response present; sampled with spi_txdata
// BEHAVIOUR
//  Reset: spi_miso=0, spi_cmd=0, spi_rxdata=0, spi_rxlen=0, spi_msg_end=0, state IDLE;
//   ssel sync chain resets to 1, sclk chain to 0 (no spurious edges after reset).
//  Edges: rise/fall = change between last sync stage and edge flop; each edge acts in the cycle detected.
//   Pin-to-action latency SYNC_STAGES+1 clk.
//  FSM: IDLE -(ssel fall)-> CMD -(8th bit)-> DATA -(ssel rise)-> IDLE; CMD -(ssel rise)-> IDLE.
//   IDLE leaves only on ssel fall: reset mid-message ignores rest of that window, no msg_end.
//  On ssel fall: bitcnt=0, spi_cmd=0, spi_rxdata=0, spi_rxlen=0, tx shifter=0.
//  On sclk rise with ssel low: shift mosi into 8-bit rx shifter; bitcnt mod-8 increments.
//   Byte done in CMD: spi_cmd<=byte; tx shifter<=valid ? spi_txdata : 0; go DATA.
//   Byte done in DATA: spi_rxdata<={byte, spi_rxdata[63:8]}; spi_rxlen<=min(rxlen+1,8).
//   >8 data bytes: keeps last 8; rxlen stays 8.
//  MISO: 0 during cmd byte. On each sclk fall in DATA, spi_miso<=next tx bit;
//   response byte k = spi_txdata[8k+7:8k], bit 7 first; after 8 bytes (or if !valid) 0.
//   No update on sclk rise. spi_miso driven to 0 in IDLE.
//  On ssel rise: in DATA pulse spi_msg_end the next cycle; partial trailing byte discarded (not counted).
//   In CMD (cmd byte incomplete): no pulse, spi_cmd stays 0.
//  spi_cmd/spi_rxdata/spi_rxlen hold after msg_end until next ssel fall.
//  Simultaneous sclk edge and ssel rise: sclk edge processed first, then ssel rise.
//  No double pulse: at most one msg_end per select window.
// TESTING
//  1 cmd 0x10 + bytes 01..08 -> one msg_end pulse; spi_cmd=0x10; spi_rxdata=64'h0807060504030201; spi_rxlen=8.
//  2 cmd 0x01 + byte 0x02 -> spi_rxdata=64'h0200000000000000; spi_rxlen=1; spi_cmd=0x01.
//  3 txdata=64'h8877665544332211 valid; cmd 0x20 + 3 bytes -> MISO bytes 00,11,22,33; valid=0 -> all 00.
//  4 cmd 0x10 + bytes 01..0A -> spi_rxdata=64'h0A09080706050403; spi_rxlen=8.
//  5 deselect after 5 cmd bits -> no msg_end, spi_cmd=0; cmd 0x11 + 3 bits -> msg_end, rxlen=0, rxdata=0.
//  6 reset_n low 2 clk mid-data-byte, ssel low -> rest of window ignored, no msg_end; next msg (case 1) correct.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversamples the async SPI pins in clk, frames each select
// window as a command byte plus data bytes, and shifts the registered response out on MISO.
module spi_slave_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_sclk,
    input  logic        spi_ssel_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [7:0]  spi_cmd,
    output logic [63:0] spi_rxdata,
    output logic [3:0]  spi_rxlen,
    output logic        spi_msg_end,
    input  logic [63:0] spi_txdata,
    input  logic        spi_txdata_valid
);

    // state | meaning
    // IDLE  | deselected, MISO held low, waiting for ssel fall
    // CMD   | receiving the command byte
    // DATA  | receiving data bytes, shifting the response out on MISO
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ssel_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_edge_q;
    logic                   ssel_edge_q;
    logic [SETTLE_W-1:0]    settle_q;

    state_t      state_q, state_d, state_mid;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [63:0] tx_sh_q, tx_sh_d;
    logic        miso_q, miso_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [63:0] rxdata_q, rxdata_d;
    logic [3:0]  rxlen_q, rxlen_d;
    logic        msg_end_q, msg_end_d;

    logic        sclk_s, ssel_s, mosi_s;
    logic        sclk_rise, sclk_fall, ssel_rise, ssel_fall;
    logic [7:0]  rx_byte;
    logic [63:0] tx_load;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ssel_s = ssel_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_edge_q;
    assign sclk_fall = ~sclk_s & sclk_edge_q;
    assign ssel_rise = ssel_s & ~ssel_edge_q;
    // A select already low when reset releases must not open a window: the chain
    // flushes from its reset value of 1 before falls are trusted.
    assign ssel_fall = ~ssel_s & ssel_edge_q & (settle_q == '0);

    assign rx_byte = {rx_sh_q[6:0], mosi_s};

    // Byte-reverse so response byte 0 sits at the top of the shifter, bit 7 first.
    always_comb begin
        tx_load = '0;
        for (int k = 0; k < 8; k++) begin
            tx_load[63-8*k -: 8] = spi_txdata[8*k+7 -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            ssel_sync_q <= '1;
            mosi_sync_q <= '0;
            sclk_edge_q <= 1'b0;
            ssel_edge_q <= 1'b1;
            settle_q    <= SETTLE_INIT;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], spi_ssel_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_edge_q <= sclk_s;
            ssel_edge_q <= ssel_s;
            if (settle_q != '0) begin
                settle_q <= settle_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= '0;
            miso_q    <= 1'b0;
            cmd_q     <= '0;
            rxdata_q  <= '0;
            rxlen_q   <= '0;
            msg_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            rx_sh_q   <= rx_sh_d;
            tx_sh_q   <= tx_sh_d;
            miso_q    <= miso_d;
            cmd_q     <= cmd_d;
            rxdata_q  <= rxdata_d;
            rxlen_q   <= rxlen_d;
            msg_end_q <= msg_end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        state_mid = state_q;
        bitcnt_d  = bitcnt_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        miso_d    = miso_q;
        cmd_d     = cmd_q;
        rxdata_d  = rxdata_q;
        rxlen_d   = rxlen_q;
        msg_end_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ssel_fall) begin
                    state_d  = ST_CMD;
                    bitcnt_d = '0;
                    rx_sh_d  = '0;
                    tx_sh_d  = '0;
                    cmd_d    = '0;
                    rxdata_d = '0;
                    rxlen_d  = '0;
                end
            end
            ST_CMD, ST_DATA: begin
                if (sclk_rise) begin
                    rx_sh_d  = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (state_q == ST_CMD) begin
                            cmd_d     = rx_byte;
                            tx_sh_d   = spi_txdata_valid ? tx_load : 64'd0;
                            state_mid = ST_DATA;
                        end else begin
                            rxdata_d = {rx_byte, rxdata_q[63:8]};
                            if (rxlen_q != 4'd8) begin
                                rxlen_d = rxlen_q + 4'd1;
                            end
                        end
                    end
                end
                if (sclk_fall && state_q == ST_DATA) begin
                    miso_d  = tx_sh_q[63];
                    tx_sh_d = {tx_sh_q[62:0], 1'b0};
                end
                // The sclk edge above is folded in first, so a byte finishing on the
                // same cycle as deselect still ends the message.
                if (ssel_rise) begin
                    state_d   = ST_IDLE;
                    msg_end_d = (state_mid == ST_DATA);
                end else begin
                    state_d = state_mid;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    assign spi_miso    = miso_q;
    assign spi_cmd     = cmd_q;
    assign spi_rxdata  = rxdata_q;
    assign spi_rxlen   = rxlen_q;
    assign spi_msg_end = msg_end_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: drives SPI mode-0 frames at clk/8 and checks the
// captured message, the end-of-message pulse and the MISO response bytes.
module tb_spi_slave_if;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        spi_sclk;
    logic        spi_ssel_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [7:0]  spi_cmd;
    logic [63:0] spi_rxdata;
    logic [3:0]  spi_rxlen;
    logic        spi_msg_end;
    logic [63:0] spi_txdata;
    logic        spi_txdata_valid;

    int checks = 0;
    int errors = 0;

    int          pulse_total = 0;
    logic [7:0]  cap_cmd = '0;
    logic [63:0] cap_rxdata = '0;
    logic [3:0]  cap_rxlen = '0;

    always #5 clk = ~clk;

    spi_slave_if #(.SYNC_STAGES(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .spi_sclk         (spi_sclk),
        .spi_ssel_n       (spi_ssel_n),
        .spi_mosi         (spi_mosi),
        .spi_miso         (spi_miso),
        .spi_cmd          (spi_cmd),
        .spi_rxdata       (spi_rxdata),
        .spi_rxlen        (spi_rxlen),
        .spi_msg_end      (spi_msg_end),
        .spi_txdata       (spi_txdata),
        .spi_txdata_valid (spi_txdata_valid)
    );

    // Counts high cycles of msg_end, so a stretched pulse shows up as >1.
    always @(negedge clk) begin
        if (spi_msg_end) begin
            pulse_total <= pulse_total + 1;
            cap_cmd     <= spi_cmd;
            cap_rxdata  <= spi_rxdata;
            cap_rxlen   <= spi_rxlen;
        end
    end

    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] miso_b);
        miso_b = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            repeat (4) @(negedge clk);
            miso_b = {miso_b[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic select_win();
        spi_ssel_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic deselect_win();
        repeat (4) @(negedge clk);
        spi_ssel_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_msg(input string name, input int npulse, input logic [7:0] cmd,
                             input logic [63:0] rxdata, input logic [3:0] rxlen);
        checks++;
        if (npulse !== 1) begin
            errors++;
            $display("FAIL %s pulses got %0d exp 1", name, npulse);
        end
        checks++;
        if (spi_cmd !== cmd) begin
            errors++;
            $display("FAIL %s cmd got %h exp %h", name, spi_cmd, cmd);
        end
        checks++;
        if (spi_rxdata !== rxdata) begin
            errors++;
            $display("FAIL %s rxdata got %h exp %h", name, spi_rxdata, rxdata);
        end
        checks++;
        if (spi_rxlen !== rxlen) begin
            errors++;
            $display("FAIL %s rxlen got %0d exp %0d", name, spi_rxlen, rxlen);
        end
        checks++;
        if (cap_rxdata !== rxdata || cap_cmd !== cmd || cap_rxlen !== rxlen) begin
            errors++;
            $display("FAIL %s at_pulse got %h/%h/%0d exp %h/%h/%0d", name,
                     cap_cmd, cap_rxdata, cap_rxlen, cmd, rxdata, rxlen);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({spi_miso, spi_cmd, spi_rxdata, spi_rxlen, spi_msg_end} !== '0) begin
            errors++;
            $display("FAIL reset got miso=%b cmd=%h rx=%h len=%0d end=%b exp all 0",
                     spi_miso, spi_cmd, spi_rxdata, spi_rxlen, spi_msg_end);
        end
    endtask

    task automatic test_eight_bytes();
        logic [7:0] m;
        int p0 = pulse_total;
        select_win();
        send_bits(8'h10, 8, m);
        for (int i = 0; i < 8; i++) send_bits(8'(i + 1), 8, m);
        deselect_win();
        check_msg("eight_bytes", pulse_total - p0, 8'h10, 64'h0807060504030201, 4'd8);
        repeat (20) @(negedge clk);
        checks++;
        if (spi_cmd !== 8'h10 || spi_rxlen !== 4'd8 || pulse_total - p0 !== 1) begin
            errors++;
            $display("FAIL hold got cmd=%h len=%0d pulses=%0d exp 10/8/1",
                     spi_cmd, spi_rxlen, pulse_total - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m;
        int p0 = pulse_total;
        select_win();
        send_bits(8'h01, 8, m);
        send_bits(8'h02, 8, m);
        deselect_win();
        check_msg("one_byte", pulse_total - p0, 8'h01, 64'h0200000000000000, 4'd1);
    endtask

    task automatic test_miso();
        logic [7:0] m0, m1, m2, m3;
        spi_txdata = 64'h8877665544332211;
        spi_txdata_valid = 1'b1;
        select_win();
        send_bits(8'h20, 8, m0);
        send_bits(8'hA5, 8, m1);
        send_bits(8'h5A, 8, m2);
        send_bits(8'hC3, 8, m3);
        deselect_win();
        checks++;
        if ({m0, m1, m2, m3} !== 32'h00112233) begin
            errors++;
            $display("FAIL miso_valid got %h exp 00112233", {m0, m1, m2, m3});
        end
        checks++;
        if (spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL miso_idle got %b exp 0", spi_miso);
        end
        checks++;
        if (spi_rxdata !== 64'hC35AA50000000000 || spi_rxlen !== 4'd3) begin
            errors++;
            $display("FAIL miso_rx got %h/%0d exp c35aa50000000000/3", spi_rxdata, spi_rxlen);
        end
        spi_txdata_valid = 1'b0;
        select_win();
        send_bits(8'h21, 8, m0);
        send_bits(8'hFF, 8, m1);
        send_bits(8'hFF, 8, m2);
        send_bits(8'hFF, 8, m3);
        deselect_win();
        checks++;
        if ({m0, m1, m2, m3} !== 32'h00000000) begin
            errors++;
            $display("FAIL miso_invalid got %h exp 00000000", {m0, m1, m2, m3});
        end
        spi_txdata = '0;
    endtask

    task automatic test_overflow();
        logic [7:0] m;
        int p0 = pulse_total;
        select_win();
        send_bits(8'h10, 8, m);
        for (int i = 0; i < 10; i++) send_bits(8'(i + 1), 8, m);
        deselect_win();
        check_msg("overflow", pulse_total - p0, 8'h10, 64'h0A09080706050403, 4'd8);
    endtask

    task automatic test_partial();
        logic [7:0] m;
        int p0 = pulse_total;
        select_win();
        send_bits(8'hFF, 5, m);
        deselect_win();
        checks++;
        if (pulse_total - p0 !== 0 || spi_cmd !== 8'h00) begin
            errors++;
            $display("FAIL partial_cmd got pulses=%0d cmd=%h exp 0/00", pulse_total - p0, spi_cmd);
        end
        p0 = pulse_total;
        select_win();
        send_bits(8'h11, 8, m);
        send_bits(8'hFF, 3, m);
        deselect_win();
        check_msg("partial_data", pulse_total - p0, 8'h11, 64'h0, 4'd0);
    endtask

    task automatic test_reset_mid_msg();
        logic [7:0] m;
        int p0 = pulse_total;
        select_win();
        send_bits(8'h10, 8, m);
        send_bits(8'h01, 8, m);
        send_bits(8'hFF, 3, m);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_bits(8'hFF, 5, m);
        send_bits(8'h0F, 8, m);
        deselect_win();
        checks++;
        if (pulse_total - p0 !== 0 || spi_cmd !== 8'h00 || spi_rxlen !== 4'd0 || spi_rxdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid got pulses=%0d cmd=%h len=%0d rx=%h exp 0/00/0/0",
                     pulse_total - p0, spi_cmd, spi_rxlen, spi_rxdata);
        end
        test_eight_bytes();
    endtask

    initial begin
        reset_n          = 1'b0;
        spi_sclk         = 1'b0;
        spi_ssel_n       = 1'b1;
        spi_mosi         = 1'b0;
        spi_txdata       = '0;
        spi_txdata_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        test_reset();
        test_eight_bytes();
        test_back_to_back();
        test_miso();
        test_overflow();
        test_partial();
        test_reset_mid_msg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
